dot_accumulator: RTL and testbench
==================================

# dot_accumulator

Sequential accumulation stage directly downstream of the combinational adder tree in the attention datapath. Each accepted beat is one adder-tree partial sum, covering one chunk of a dot product. The block accumulates NUM_CHUNKS consecutive beats into a full dot-product score and presents it on a registered output with a valid/ready handshake. Output buffering lets accumulation of the next vector overlap with draining of the previous result.

## Interface
- IN_WIDTH, 18: width of the adder-tree sum (16-bit operands, 4-wide tree: 16 + 2).
- NUM_CHUNKS, 16: beats per dot product; must be at least 1.
- OUT_WIDTH, IN_WIDTH + $clog2(NUM_CHUNKS): result width; sized so the sum can never overflow.
- CNT_WIDTH, max(1, $clog2(NUM_CHUNKS)): width of the chunk counter (local, not overridable).

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous flush of the partial accumulation.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block accepts in_data this cycle.
- in_data  in  IN_WIDTH  unsigned partial sum from the adder tree.
- out_valid  out  1  out_data holds a completed dot product.
- out_ready  in  1  consumer accepts out_data.
- out_data  out  OUT_WIDTH  unsigned completed dot product.

## Operation
- All arithmetic is unsigned. in_data is zero-extended to OUT_WIDTH before it is added.
- State held: acc (OUT_WIDTH bits), cnt (CNT_WIDTH bits), out_reg, and an output flag (EMPTY/FULL, which drives out_valid).
- An input handshake occurs when in_valid and in_ready are both high. An output handshake occurs when out_valid and out_ready are both high.
- Non-final beat (cnt < NUM_CHUNKS-1):
  - acc <= acc + in_data; cnt <= cnt + 1.
  - Never stalled by the output side.
- Final beat (cnt == NUM_CHUNKS-1):
  - out_reg <= acc + in_data; output flag becomes FULL.
  - acc <= 0; cnt <= 0.
- in_ready = !clear && !(cnt == NUM_CHUNKS-1 && out_valid && !out_ready).
  - The final beat may be accepted in the same cycle that the held result drains.
- Output flag transitions:
  - EMPTY → FULL on a final-beat handshake.
  - FULL → EMPTY on an output handshake with no final-beat handshake.
  - FULL stays FULL when both handshakes occur in the same cycle; out_reg is replaced.
- While FULL, out_data and out_valid hold stable until the output handshake.
- clear:
  - acc <= 0; cnt <= 0; in_ready is forced low, so no beat is consumed.
  - out_reg and the output flag are untouched; a pending result can still drain during clear.
- NUM_CHUNKS == 1: every accepted beat is a final beat, so the block acts as a registered pass-through with backpressure.

## Timing
- Reset values: out_valid = 0, out_data = 0, in_ready = 1, acc = 0, cnt = 0.
- Reset asserted mid-vector discards the partial sum and any pending result immediately (asynchronous).
- Latency: out_valid rises in the cycle after the final-beat handshake.
- Throughput: one beat per cycle and one result per NUM_CHUNKS cycles, with no bubbles while out_ready is held high.
- in_ready has a combinational path from out_ready and clear. No other input-to-output combinational paths.
- Backpressure stalls only the final beat. Non-final beats of the next vector continue to be accepted while a result is held.

## Structure
- The shared attention package holds the default widths (DATA_WIDTH = 16, TREE_LEN = 4), so IN_WIDTH stays consistent with the adder tree instance.
- The output flag encoding (EMPTY/FULL) is local to the block.
- One sub-module is natural: out_stage, a one-entry valid/ready output register (load, drain, simultaneous load+drain). It is reusable by other attention stages.
- Accumulator and counter stay in the top module.

## Test plan
Bench configuration: IN_WIDTH = 18, NUM_CHUNKS = 4.
1. Reset, then beats 10, 20, 30, 40 back-to-back with out_ready = 1:
   - out_data = 100, out_valid high for exactly 1 cycle, one cycle after the 4th beat.
2. Streaming, out_ready held 1, all beats = 0x3FFFF:
   - results of 0xFFFFC every 4 cycles; no overflow; in_ready never drops.
3. First result held with out_ready = 0; second vector of beats 1, 2, 3, 4:
   - three beats accepted, in_ready drops on the 4th.
   - Raising out_ready drains 100, the 4th beat is accepted in that same cycle, and 10 appears the next cycle.
4. Two beats of 5, then clear for one cycle (in_valid high), then 4 beats of 1:
   - in_ready low during clear; result = 4.
5. rst_n asserted after 2 beats, with a held result present:
   - out_valid drops immediately; the next 4 beats of 7 give 28.
6. Random valid/ready toggling over 1000 vectors against a reference model:
   - every result matches; no result is lost or duplicated; out_data is stable while stalled.

Source files
------------

// File: rtl/dot_accumulator_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dot_accumulator_pkg
// Description : Shared attention-datapath widths and helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package dot_accumulator_pkg;

    localparam int DATA_WIDTH     = 16;
    localparam int TREE_LEN       = 4;
    localparam int DEF_IN_WIDTH   = DATA_WIDTH + $clog2(TREE_LEN);
    localparam int DEF_NUM_CHUNKS = 16;

    // A single-chunk dot product still needs a one-bit counter to exist.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dot_accumulator_if.sv
`default_nettype none
// ============================================================================
// Module      : dot_accumulator_if
// Description : Partial-sum input stream, result output stream and flush.
// Revision    : 1.0 - initial release
// ============================================================================
interface dot_accumulator_if
    import dot_accumulator_pkg::*;
#(
    parameter int IN_WIDTH  = DEF_IN_WIDTH,
    parameter int OUT_WIDTH = DEF_IN_WIDTH + $clog2(DEF_NUM_CHUNKS)
) ();

    logic                 clear;
    logic                 in_valid;
    logic                 in_ready;
    logic [IN_WIDTH-1:0]  in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [OUT_WIDTH-1:0] out_data;

    modport master (
        output clear, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  clear, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );

endinterface
`default_nettype wire

// File: rtl/dot_accumulator_out_stage.sv
`default_nettype none
// ============================================================================
// Module      : dot_accumulator_out_stage
// Description : One-entry valid/ready output register (load, drain, both).
// Revision    : 1.0 - initial release
// ============================================================================
module dot_accumulator_out_stage #(
    parameter int WIDTH = 20
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             load,
    input  wire logic [WIDTH-1:0] load_data,
    output logic                  valid,
    input  wire logic             ready,
    output logic [WIDTH-1:0]      data
);

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } flag_e;

    flag_e            flag_q, flag_d;
    logic [WIDTH-1:0] data_q, data_d;

    always_comb begin
        flag_d = flag_q;
        data_d = data_q;
        // A load in the same cycle as a drain keeps the entry occupied.
        if (load) begin
            flag_d = FULL;
            data_d = load_data;
        end else if (flag_q == FULL && ready) begin
            flag_d = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_q <= EMPTY;
            data_q <= '0;
        end else begin
            flag_q <= flag_d;
            data_q <= data_d;
        end
    end

    assign valid = (flag_q == FULL);
    assign data  = data_q;

endmodule
`default_nettype wire

// File: rtl/dot_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : dot_accumulator
// Description : Accumulates NUM_CHUNKS adder-tree partial sums per dot product.
// Revision    : 1.0 - initial release
// ============================================================================
module dot_accumulator
    import dot_accumulator_pkg::*;
#(
    parameter int IN_WIDTH   = DEF_IN_WIDTH,
    parameter int NUM_CHUNKS = DEF_NUM_CHUNKS,
    parameter int OUT_WIDTH  = IN_WIDTH + $clog2(NUM_CHUNKS)
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    dot_accumulator_if.slave  bus
);

    localparam int CNT_WIDTH = cnt_width(NUM_CHUNKS);
    localparam logic [CNT_WIDTH-1:0] C_LAST_CNT = CNT_WIDTH'(NUM_CHUNKS - 1);

    logic [OUT_WIDTH-1:0] acc_q, acc_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [OUT_WIDTH-1:0] sum;
    logic                 last_beat;
    logic                 in_ready;
    logic                 in_hs;
    logic                 out_valid;

    assign last_beat = (cnt_q == C_LAST_CNT);
    assign sum       = acc_q + OUT_WIDTH'(bus.in_data);

    // Only the final beat needs a free output slot; it may take the slot
    // being vacated in the same cycle.
    assign in_ready = !bus.clear && !(last_beat && out_valid && !bus.out_ready);
    assign in_hs    = bus.in_valid && in_ready;

    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        if (bus.clear) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (in_hs) begin
            if (last_beat) begin
                acc_d = '0;
                cnt_d = '0;
            end else begin
                acc_d = sum;
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

    dot_accumulator_out_stage #(
        .WIDTH (OUT_WIDTH)
    ) u_out_stage (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (in_hs && last_beat),
        .load_data (sum),
        .valid     (out_valid),
        .ready     (bus.out_ready),
        .data      (bus.out_data)
    );

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;

endmodule
`default_nettype wire

// File: tb/tb_dot_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_dot_accumulator
// Description : Directed and randomized self-checking bench for dot_accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dot_accumulator;

    localparam int C_IN_W  = 18;
    localparam int C_NC    = 4;
    localparam int C_OUT_W = 20;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dot_accumulator_if #(.IN_WIDTH(C_IN_W), .OUT_WIDTH(C_OUT_W)) bus ();

    dot_accumulator #(
        .IN_WIDTH   (C_IN_W),
        .NUM_CHUNKS (C_NC),
        .OUT_WIDTH  (C_OUT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: beats of the current vector, and results owed downstream.
    logic [31:0] cur_beats[$];
    logic [31:0] expq[$];
    int          n_drained = 0;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_data;

    always @(negedge clk) begin
        logic [31:0] s;
        if (!rst_n) begin
            cur_beats.delete();
            expq.delete();
            prev_stall = 1'b0;
        end else begin
            check("out_valid_model", {31'b0, bus.out_valid}, {31'b0, expq.size() != 0});
            check("in_ready_rule", {31'b0, bus.in_ready},
                  {31'b0, !bus.clear && !(cur_beats.size() == C_NC - 1 && bus.out_valid && !bus.out_ready)});
            if (prev_stall) check("stall_hold", {12'b0, bus.out_data}, prev_data);
            if (bus.out_valid && bus.out_ready && expq.size() != 0) begin
                check("result", {12'b0, bus.out_data}, expq.pop_front());
                n_drained++;
            end
            if (bus.clear) begin
                cur_beats.delete();
            end else if (bus.in_valid && bus.in_ready) begin
                cur_beats.push_back({14'b0, bus.in_data});
                if (cur_beats.size() == C_NC) begin
                    s = 0;
                    foreach (cur_beats[k]) s += cur_beats[k];
                    expq.push_back(s);
                    cur_beats.delete();
                end
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = {12'b0, bus.out_data};
        end
    end

    initial begin
        int start;
        int cyc;
        bus.clear     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;

        // Reset values
        repeat (3) step();
        check("rst_out_valid", {31'b0, bus.out_valid}, 0);
        check("rst_out_data", {12'b0, bus.out_data}, 0);
        check("rst_in_ready", {31'b0, bus.in_ready}, 1);
        rst_n = 1'b1;
        step();

        // 1: 10,20,30,40 back to back
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 18'(10 * (i + 1));
            step();
            if (i < 3) check("t1_no_early_valid", {31'b0, bus.out_valid}, 0);
        end
        check("t1_valid", {31'b0, bus.out_valid}, 1);
        check("t1_data", {12'b0, bus.out_data}, 100);
        bus.in_valid = 1'b0;
        step();
        check("t1_valid_one_cycle", {31'b0, bus.out_valid}, 0);

        // 2: streaming max-value beats
        for (int i = 0; i < 12; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 18'h3FFFF;
            #1;
            check("t2_in_ready", {31'b0, bus.in_ready}, 1);
            step();
            check("t2_valid", {31'b0, bus.out_valid}, {31'b0, (i % 4) == 3});
            if ((i % 4) == 3) check("t2_data", {12'b0, bus.out_data}, 32'hFFFFC);
        end
        bus.in_valid = 1'b0;
        step();

        // 3: held result, next vector stalls on its final beat only
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 18'(10 * (i + 1));
            step();
        end
        check("t3_held_valid", {31'b0, bus.out_valid}, 1);
        for (int i = 1; i <= 3; i++) begin
            bus.in_data = 18'(i);
            #1;
            check("t3_nonfinal_ready", {31'b0, bus.in_ready}, 1);
            step();
        end
        bus.in_data = 18'd4;
        for (int i = 0; i < 2; i++) begin
            #1;
            check("t3_final_stalled", {31'b0, bus.in_ready}, 0);
            step();
            check("t3_hold_data", {12'b0, bus.out_data}, 100);
        end
        bus.out_ready = 1'b1;
        #1;
        check("t3_ready_on_drain", {31'b0, bus.in_ready}, 1);
        step();
        check("t3_next_valid", {31'b0, bus.out_valid}, 1);
        check("t3_next_data", {12'b0, bus.out_data}, 10);
        bus.in_valid = 1'b0;
        step();
        check("t3_empty", {31'b0, bus.out_valid}, 0);

        // 4: clear mid-vector
        for (int i = 0; i < 2; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 18'd5;
            step();
        end
        bus.clear = 1'b1;
        #1;
        check("t4_clear_ready", {31'b0, bus.in_ready}, 0);
        step();
        bus.clear   = 1'b0;
        bus.in_data = 18'd1;
        for (int i = 0; i < 4; i++) step();
        check("t4_valid", {31'b0, bus.out_valid}, 1);
        check("t4_data", {12'b0, bus.out_data}, 4);
        bus.in_valid = 1'b0;
        step();

        // 5: async reset with a held result and a partial vector
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 18'd9;
        for (int i = 0; i < 4; i++) step();
        bus.in_data = 18'd3;
        for (int i = 0; i < 2; i++) step();
        bus.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("t5_rst_valid", {31'b0, bus.out_valid}, 0);
        check("t5_rst_data", {12'b0, bus.out_data}, 0);
        step();
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 18'd7;
        for (int i = 0; i < 4; i++) step();
        check("t5_valid", {31'b0, bus.out_valid}, 1);
        check("t5_data", {12'b0, bus.out_data}, 28);
        bus.in_valid = 1'b0;
        step();

        // 6: random handshakes against the model
        start = n_drained;
        cyc   = 0;
        while ((n_drained - start) < 1000 && cyc < 40000) begin
            bus.in_valid  = ($urandom_range(0, 9) < 7);
            bus.in_data   = ($urandom_range(0, 3) == 0) ? 18'h3FFFF : 18'($urandom);
            bus.out_ready = ($urandom_range(0, 9) < 6);
            bus.clear     = ($urandom_range(0, 99) == 0);
            step();
            cyc++;
        end
        check("rand_results", n_drained - start, 1000);

        bus.in_valid  = 1'b0;
        bus.clear     = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) step();
        check("final_empty", {31'b0, bus.out_valid}, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
